// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file:
// sweep state encoding and address-width helper.
package reg_file_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // Ceiling log2 with a floor of 1 so a 2-entry file still has an address bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_file_sweep_ctrl.sv
// Clear-sweep sequencer: walks registers 1..DEPTH-1, one per cycle,
// and reports the index being zeroed.
module reg_file_sweep_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_strobe,
    output logic [ADDR_W-1:0] o_idx
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= ST_SWEEP;
                        r_cnt   <= ADDR_W'(1);
                    end
                end
                ST_SWEEP: begin
                    if (r_cnt == LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy   = (r_state == ST_SWEEP);
    assign o_strobe = (r_state == ST_SWEEP);
    assign o_idx    = r_cnt;

endmodule

// File: rtl/reg_file_scb.sv
// Register file with per-register pending (scoreboard) bits,
// write-to-read bypass and a sequential clear sweep.
module reg_file_scb
    import reg_file_pkg::*;
#(
    parameter  int N      = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Reg_Write_i,
    input  logic [ADDR_W-1:0] Write_Register_i,
    input  logic [N-1:0]      Write_Data_i,
    input  logic [ADDR_W-1:0] Read_Register_1_i,
    input  logic [ADDR_W-1:0] Read_Register_2_i,
    output logic [N-1:0]      Read_Data_1_o,
    output logic [N-1:0]      Read_Data_2_o,
    input  logic              Reserve_i,
    input  logic [ADDR_W-1:0] Reserve_Register_i,
    output logic              Pending_1_o,
    output logic              Pending_2_o,
    input  logic              Clear_i,
    output logic              Busy_o
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [N-1:0]      r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic              w_busy;
    logic              w_strobe;
    logic [ADDR_W-1:0] w_idx;
    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic              w_hit1;
    logic              w_hit2;
    logic [N-1:0]      w_rd1;
    logic [N-1:0]      w_rd2;
    logic              w_pd1;
    logic              w_pd2;

    reg_file_sweep_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (Clear_i),
        .o_busy   (w_busy),
        .o_strobe (w_strobe),
        .o_idx    (w_idx)
    );

    assign w_wr_ok  = Reg_Write_i && !w_busy
                   && (Write_Register_i != '0)
                   && ({1'b0, Write_Register_i} < DEPTH_L);
    assign w_rsv_ok = Reserve_i && !w_busy
                   && (Reserve_Register_i != '0)
                   && ({1'b0, Reserve_Register_i} < DEPTH_L);

    // Entry 0 is reset and never written, so it stays a constant zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (w_strobe && (w_idx == ADDR_W'(k))) begin
                    r_regs[k] <= '0;
                    r_pend[k] <= 1'b0;
                end else begin
                    if (w_wr_ok && (Write_Register_i == ADDR_W'(k)))
                        r_regs[k] <= Write_Data_i;
                    if (w_rsv_ok && (Reserve_Register_i == ADDR_W'(k)))
                        r_pend[k] <= 1'b1;
                    else if (w_wr_ok && (Write_Register_i == ADDR_W'(k)))
                        r_pend[k] <= 1'b0;
                end
            end
        end
    end

    assign w_hit1 = w_wr_ok && (Write_Register_i == Read_Register_1_i);
    assign w_hit2 = w_wr_ok && (Write_Register_i == Read_Register_2_i);

    // Addresses at or beyond DEPTH match no entry and fall through to zero.
    always_comb begin
        w_rd1 = '0;
        w_pd1 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (Read_Register_1_i == ADDR_W'(k)) begin
                w_rd1 = r_regs[k];
                w_pd1 = r_pend[k];
            end
        end
        if (w_hit1) begin
            w_rd1 = Write_Data_i;
            w_pd1 = 1'b0;
        end
        if (!reset) begin
            w_rd1 = '0;
            w_pd1 = 1'b0;
        end
    end

    always_comb begin
        w_rd2 = '0;
        w_pd2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (Read_Register_2_i == ADDR_W'(k)) begin
                w_rd2 = r_regs[k];
                w_pd2 = r_pend[k];
            end
        end
        if (w_hit2) begin
            w_rd2 = Write_Data_i;
            w_pd2 = 1'b0;
        end
        if (!reset) begin
            w_rd2 = '0;
            w_pd2 = 1'b0;
        end
    end

    assign Read_Data_1_o = w_rd1;
    assign Read_Data_2_o = w_rd2;
    assign Pending_1_o   = w_pd1;
    assign Pending_2_o   = w_pd2;
    assign Busy_o        = w_busy;

endmodule

// File: tb/tb_reg_file_scb.sv
// Directed bench for reg_file_scb: a 32x32 instance and a 20x16
// instance sharing clock and reset.
module tb_reg_file_scb;

    logic        clk;
    logic        reset;

    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic [4:0]  a_ra1;
    logic [4:0]  a_ra2;
    logic [31:0] a_rd1;
    logic [31:0] a_rd2;
    logic        a_rsv;
    logic [4:0]  a_rsva;
    logic        a_pd1;
    logic        a_pd2;
    logic        a_clr;
    logic        a_busy;

    logic        b_we;
    logic [4:0]  b_wa;
    logic [15:0] b_wd;
    logic [4:0]  b_ra1;
    logic [4:0]  b_ra2;
    logic [15:0] b_rd1;
    logic [15:0] b_rd2;
    logic        b_rsv;
    logic [4:0]  b_rsva;
    logic        b_pd1;
    logic        b_pd2;
    logic        b_clr;
    logic        b_busy;

    int n_chk;
    int n_pass;
    int n;
    logic [31:0] acc;
    logic        pacc;

    reg_file_scb #(.N(32), .DEPTH(32)) u_dut (
        .clk                (clk),
        .reset              (reset),
        .Reg_Write_i        (a_we),
        .Write_Register_i   (a_wa),
        .Write_Data_i       (a_wd),
        .Read_Register_1_i  (a_ra1),
        .Read_Register_2_i  (a_ra2),
        .Read_Data_1_o      (a_rd1),
        .Read_Data_2_o      (a_rd2),
        .Reserve_i          (a_rsv),
        .Reserve_Register_i (a_rsva),
        .Pending_1_o        (a_pd1),
        .Pending_2_o        (a_pd2),
        .Clear_i            (a_clr),
        .Busy_o             (a_busy)
    );

    reg_file_scb #(.N(16), .DEPTH(20)) u_dut20 (
        .clk                (clk),
        .reset              (reset),
        .Reg_Write_i        (b_we),
        .Write_Register_i   (b_wa),
        .Write_Data_i       (b_wd),
        .Read_Register_1_i  (b_ra1),
        .Read_Register_2_i  (b_ra2),
        .Read_Data_1_o      (b_rd1),
        .Read_Data_2_o      (b_rd2),
        .Reserve_i          (b_rsv),
        .Reserve_Register_i (b_rsva),
        .Pending_1_o        (b_pd1),
        .Pending_2_o        (b_pd2),
        .Clear_i            (b_clr),
        .Busy_o             (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_we = 0; a_wa = 0; a_wd = 0; a_rsv = 0; a_rsva = 0; a_clr = 0;
    endtask

    task automatic a_write(input logic [4:0] ad, input logic [31:0] d);
        a_we = 1; a_wa = ad; a_wd = d;
        tick();
        a_we = 0;
    endtask

    task automatic a_fill();
        for (int k = 1; k < 32; k++) a_write(5'(k), 32'h1000 + 32'(k));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 0;
        a_idle();
        a_ra1 = 0; a_ra2 = 0;
        b_we = 0; b_wa = 0; b_wd = 0; b_rsv = 0; b_rsva = 0; b_clr = 0;
        b_ra1 = 0; b_ra2 = 0;
        #12;
        chk("rst_busy", 64'(a_busy), 64'd0);
        a_ra1 = 5; a_we = 1; a_wa = 5; a_wd = 32'h1234; #1;
        chk("rst_rd_no_bypass", 64'(a_rd1), 64'd0);
        chk("rst_pend", 64'(a_pd1), 64'd0);
        a_idle();
        @(negedge clk);
        reset = 1;
        tick();

        a_write(5'd10, 32'h14);
        a_ra2 = 10; #1;
        chk("r10_read", 64'(a_rd2), 64'h14);
        a_write(5'd0, 32'h5);
        a_ra1 = 0; #1;
        chk("r0_read", 64'(a_rd1), 64'd0);

        a_ra1 = 4; #1;
        chk("r4_before", 64'(a_rd1), 64'd0);
        a_we = 1; a_wa = 4; a_wd = 32'hDEAD; #1;
        chk("bypass_r4", 64'(a_rd1), 64'hDEAD);
        tick(); a_idle(); #1;
        chk("r4_after", 64'(a_rd1), 64'hDEAD);

        a_rsv = 1; a_rsva = 7;
        tick(); a_idle();
        a_ra1 = 7; #1;
        chk("pend_r7_set", 64'(a_pd1), 64'd1);
        a_we = 1; a_wa = 7; a_wd = 9; #1;
        chk("pend_r7_hit", 64'(a_pd1), 64'd0);
        chk("bypass_r7", 64'(a_rd1), 64'd9);
        tick(); a_idle(); #1;
        chk("pend_r7_after", 64'(a_pd1), 64'd0);
        chk("r7_data", 64'(a_rd1), 64'd9);

        a_we = 1; a_wa = 3; a_wd = 32'h55; a_rsv = 1; a_rsva = 3;
        tick(); a_idle();
        a_ra1 = 3; a_ra2 = 3; #1;
        chk("r3_data", 64'(a_rd1), 64'h55);
        chk("r3_pend", 64'(a_pd2), 64'd1);

        a_rsv = 1; a_rsva = 0;
        tick(); a_idle();
        a_ra1 = 0; #1;
        chk("r0_no_pend", 64'(a_pd1), 64'd0);

        a_fill();
        a_ra1 = 31; #1;
        chk("fill_r31", 64'(a_rd1), 64'h101F);
        a_clr = 1;
        tick();
        a_clr = 0;
        a_we = 1; a_wa = 1; a_wd = 32'hFFFF;
        a_rsv = 1; a_rsva = 2;
        a_ra1 = 1; #1;
        chk("sweep_no_bypass", 64'(a_rd1), 64'h1001);
        n = 0;
        while (a_busy && n < 100) begin
            n++;
            tick();
        end
        a_idle();
        chk("sweep_cycles", 64'(n), 64'd31);
        acc = 0; pacc = 0;
        for (int k = 0; k < 32; k++) begin
            a_ra1 = 5'(k); #1;
            acc = acc | a_rd1;
            pacc = pacc | a_pd1;
        end
        chk("sweep_all_zero", 64'(acc), 64'd0);
        chk("sweep_pend_zero", 64'(pacc), 64'd0);

        a_fill();
        a_clr = 1;
        tick();
        a_clr = 0;
        for (int k = 0; k < 9; k++) tick();
        a_ra1 = 10; a_ra2 = 12; #1;
        chk("mid_sweep_busy", 64'(a_busy), 64'd1);
        chk("mid_sweep_r12", 64'(a_rd2), 64'h100C);
        a_we = 1; a_wa = 12; a_wd = 32'h77;
        reset = 0; #1;
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_rd1", 64'(a_rd1), 64'd0);
        chk("abort_rd2", 64'(a_rd2), 64'd0);
        a_idle();
        @(negedge clk);
        reset = 1;
        a_write(5'd12, 32'h77);
        #1;
        chk("post_abort_busy", 64'(a_busy), 64'd0);
        chk("post_abort_r12", 64'(a_rd2), 64'h77);
        chk("post_abort_r10", 64'(a_rd1), 64'd0);

        b_we = 1; b_wa = 19; b_wd = 16'hBEEF;
        tick();
        b_wa = 25; b_wd = 16'h1111;
        b_rsv = 1; b_rsva = 25;
        b_ra1 = 19; b_ra2 = 25; #1;
        chk("b_r19", 64'(b_rd1), 64'hBEEF);
        chk("b_a25_bypass", 64'(b_rd2), 64'd0);
        tick();
        b_we = 0; b_rsv = 0; #1;
        chk("b_a25_rd", 64'(b_rd2), 64'd0);
        chk("b_a25_pend", 64'(b_pd2), 64'd0);
        b_clr = 1;
        tick();
        b_clr = 0;
        n = 0;
        while (b_busy && n < 100) begin
            n++;
            tick();
        end
        chk("b_sweep_cycles", 64'(n), 64'd19);
        #1;
        chk("b_r19_cleared", 64'(b_rd1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
